// File: rtl/conway_hw_pkg.sv
// Shared widths and sizing helpers for the serial frame path.
package conway_hw_pkg;

  localparam int unsigned DEFAULT_BOARD_WIDTH = 64;
  localparam int unsigned FRAME_CNT_W         = 16;

  // Beat counter needs at least one bit even for single-beat frames.
  function automatic int unsigned beat_cnt_w(input int unsigned beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/shift_accumulator.sv
// Collects LANES-wide beats into a DATA_SIZE frame; exposes the frame that
// would result from accepting the current beat so the top can load it directly.
module shift_accumulator
  import conway_hw_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEFAULT_BOARD_WIDTH,
  parameter int unsigned LANES     = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [LANES-1:0]     data_in,
  input  logic                 accept,
  input  logic                 align,
  output logic                 last_beat_c,
  output logic [DATA_SIZE-1:0] frame_c
);

  localparam int unsigned BEATS = DATA_SIZE / LANES;
  localparam int unsigned BCW   = beat_cnt_w(BEATS);

  logic [DATA_SIZE-1:0] shift_reg;
  logic [BCW-1:0]       beat_cnt;

  assign last_beat_c = (beat_cnt == BCW'(BEATS - 1));

  // Full-width lanes bypass the shifter so no zero-width slice is formed.
  generate
    if (LANES == DATA_SIZE) begin : g_whole
      assign frame_c = data_in;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign frame_c = {shift_reg[DATA_SIZE-LANES-1:0], data_in};
    end else begin : g_lsb
      assign frame_c = {data_in, shift_reg[DATA_SIZE-1:LANES]};
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg <= '0;
      beat_cnt  <= '0;
    end else if (align) begin
      shift_reg <= '0;
      beat_cnt  <= '0;
    end else if (accept) begin
      if (last_beat_c) begin
        shift_reg <= '0;
        beat_cnt  <= '0;
      end else begin
        shift_reg <= frame_c;
        beat_cnt  <= beat_cnt + BCW'(1);
      end
    end
  end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial-to-parallel frame deserializer with a single held output frame and
// valid/ready handshakes on both sides.
module serial_frame_deserializer
  import conway_hw_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEFAULT_BOARD_WIDTH,
  parameter int unsigned LANES     = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [LANES-1:0]       DATA_IN,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic                   ALIGN,
  output logic [DATA_SIZE-1:0]   DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

  logic                 accept_c;
  logic                 load_c;
  logic                 last_beat_c;
  logic [DATA_SIZE-1:0] frame_c;

  // Only the final beat can be blocked, and only while the held frame is stuck.
  assign IN_READY = !last_beat_c || !OUT_VALID || OUT_READY;
  assign accept_c = IN_VALID && IN_READY && !ALIGN;
  assign load_c   = accept_c && last_beat_c;

  shift_accumulator #(
    .DATA_SIZE (DATA_SIZE),
    .LANES     (LANES),
    .MSB_FIRST (MSB_FIRST)
  ) u_acc (
    .CLK         (CLK),
    .RST         (RST),
    .data_in     (DATA_IN),
    .accept      (accept_c),
    .align       (ALIGN),
    .last_beat_c (last_beat_c),
    .frame_c     (frame_c)
  );

  // A new frame load wins over delivery so back-to-back frames have no bubble.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA      <= '0;
      OUT_VALID <= 1'b0;
      FRAME_CNT <= '0;
    end else if (load_c) begin
      DATA      <= frame_c;
      OUT_VALID <= 1'b1;
      FRAME_CNT <= FRAME_CNT + FRAME_CNT_W'(1);
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench: 8-bit/2-lane MSB and LSB instances share stimulus and are
// scoreboarded per cycle; a 64-bit/1-lane instance checks single-bit order.
module tb_serial_frame_deserializer;

  logic        CLK;
  logic        RST;
  logic        a_iv, a_align, a_ordy;
  logic [1:0]  a_din;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [7:0]  a_data, b_data;
  logic [15:0] a_frame_cnt, b_frame_cnt;
  logic        c_iv, c_din, c_ordy, c_in_ready, c_out_valid;
  logic [63:0] c_data;
  logic [15:0] c_frame_cnt;
  logic [63:0] pat;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  int          mcnt;
  logic [7:0]  acc_a, acc_b;
  logic [15:0] mframes;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];

  serial_frame_deserializer #(.DATA_SIZE(8), .LANES(2), .MSB_FIRST(1)) dut_a (
    .CLK(CLK), .RST(RST), .DATA_IN(a_din), .IN_VALID(a_iv), .IN_READY(a_in_ready),
    .ALIGN(a_align), .DATA(a_data), .OUT_VALID(a_out_valid), .OUT_READY(a_ordy),
    .FRAME_CNT(a_frame_cnt));

  serial_frame_deserializer #(.DATA_SIZE(8), .LANES(2), .MSB_FIRST(0)) dut_b (
    .CLK(CLK), .RST(RST), .DATA_IN(a_din), .IN_VALID(a_iv), .IN_READY(b_in_ready),
    .ALIGN(a_align), .DATA(b_data), .OUT_VALID(b_out_valid), .OUT_READY(a_ordy),
    .FRAME_CNT(b_frame_cnt));

  serial_frame_deserializer #(.DATA_SIZE(64), .LANES(1), .MSB_FIRST(1)) dut_c (
    .CLK(CLK), .RST(RST), .DATA_IN(c_din), .IN_VALID(c_iv), .IN_READY(c_in_ready),
    .ALIGN(1'b0), .DATA(c_data), .OUT_VALID(c_out_valid), .OUT_READY(c_ordy),
    .FRAME_CNT(c_frame_cnt));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mcnt    = 0;
    acc_a   = '0;
    acc_b   = '0;
    mframes = '0;
    qa.delete();
    qb.delete();
  endtask

  // One clock of shared A/B stimulus: check outputs against the model, then advance it.
  task automatic cycle(input logic iv, input logic [1:0] din, input logic al, input logic ordy);
    logic exp_ready, accept, exp_valid;
    a_iv = iv; a_din = din; a_align = al; a_ordy = ordy;
    #1;
    exp_valid = (qa.size() != 0);
    exp_ready = (mcnt != 3) || !exp_valid || ordy;
    check("a_in_ready", 64'(a_in_ready), 64'(exp_ready));
    check("b_in_ready", 64'(b_in_ready), 64'(exp_ready));
    check("a_out_valid", 64'(a_out_valid), 64'(exp_valid));
    check("b_out_valid", 64'(b_out_valid), 64'(exp_valid));
    check("a_frame_cnt", 64'(a_frame_cnt), 64'(mframes));
    if (exp_valid) begin
      check("a_data", 64'(a_data), 64'(qa[0]));
      check("b_data", 64'(b_data), 64'(qb[0]));
      if (ordy) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
    end
    accept = iv && exp_ready && !al;
    if (al) begin
      mcnt = 0; acc_a = '0; acc_b = '0;
    end else if (accept) begin
      acc_a = {acc_a[5:0], din};
      acc_b = {din, acc_b[7:2]};
      if (mcnt == 3) begin
        qa.push_back(acc_a);
        qb.push_back(acc_b);
        acc_a = '0; acc_b = '0; mcnt = 0;
        mframes++;
      end else begin
        mcnt++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous pulse placed between clock edges.
  task automatic reset_dut();
    #2 RST = 1'b1;
    #1;
    check("rst_a_data", 64'(a_data), 64'h0);
    check("rst_a_valid", 64'(a_out_valid), 64'h0);
    check("rst_a_cnt", 64'(a_frame_cnt), 64'h0);
    check("rst_a_ready", 64'(a_in_ready), 64'h1);
    check("rst_b_data", 64'(b_data), 64'h0);
    check("rst_c_ready", 64'(c_in_ready), 64'h1);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    RST = 1'b1;
    a_iv = 0; a_din = '0; a_align = 0; a_ordy = 0;
    c_iv = 0; c_din = 0; c_ordy = 0;
    pat = 64'hDEAD_BEEF_0123_4567;
    model_reset();
    #2;
    check("reset_a_data", 64'(a_data), 64'h0);
    check("reset_a_valid", 64'(a_out_valid), 64'h0);
    check("reset_a_cnt", 64'(a_frame_cnt), 64'h0);
    check("reset_a_ready", 64'(a_in_ready), 64'h1);
    check("reset_c_ready", 64'(c_in_ready), 64'h1);
    @(posedge CLK);
    #1 RST = 1'b0;

    // Basic frame, both shift directions.
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b01, 0, 0);
    check("msb_frame", 64'(a_data), 64'hB1);
    check("lsb_frame", 64'(b_data), 64'h4E);
    check("msb_valid_1edge", 64'(a_out_valid), 64'h1);
    check("msb_cnt1", 64'(a_frame_cnt), 64'h1);
    cycle(0, 2'b00, 0, 0);
    cycle(0, 2'b00, 0, 0);
    cycle(0, 2'b00, 0, 1);
    cycle(0, 2'b00, 0, 0);

    // Back-pressure: second frame's last beat stalls until the first is taken.
    reset_dut();
    cycle(1, 2'b01, 0, 0);
    cycle(1, 2'b01, 0, 0);
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b00, 0, 0);
    check("bp_stall_ready", 64'(a_in_ready), 64'h0);
    check("bp_held_frame", 64'(a_data), 64'h5A);
    cycle(1, 2'b00, 0, 1);
    check("bp_frame2", 64'(a_data), 64'hCC);
    check("bp_frame2_lsb", 64'(b_data), 64'h33);
    cycle(0, 2'b00, 0, 1);
    cycle(0, 2'b00, 0, 0);
    check("bp_cnt2", 64'(a_frame_cnt), 64'h2);

    // Streaming with the consumer always ready.
    for (int i = 0; i < 12; i++) cycle(1, 2'(i * 3 + 1), 0, 1);
    cycle(0, 2'b00, 0, 1);
    cycle(0, 2'b00, 0, 0);

    // Align drops the concurrent beat and leaves the held frame alone.
    for (int i = 0; i < 4; i++) cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b10, 1, 0);
    check("align_held", 64'(a_data), 64'hAA);
    check("align_valid", 64'(a_out_valid), 64'h1);
    cycle(1, 2'b01, 0, 1);
    cycle(1, 2'b10, 0, 1);
    cycle(1, 2'b11, 0, 1);
    cycle(1, 2'b00, 0, 1);
    check("align_fresh_msb", 64'(a_data), 64'h6C);
    check("align_fresh_lsb", 64'(b_data), 64'h39);
    cycle(0, 2'b00, 0, 1);
    cycle(0, 2'b00, 0, 0);

    // Reset mid-frame with a frame held, then a clean frame from beat 0.
    for (int i = 0; i < 4; i++) cycle(1, 2'b01, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b10, 0, 0);
    reset_dut();
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b11, 0, 0);
    check("post_rst_msb", 64'(a_data), 64'h0F);
    check("post_rst_lsb", 64'(b_data), 64'hF0);
    check("post_rst_cnt", 64'(a_frame_cnt), 64'h1);
    cycle(0, 2'b00, 0, 1);

    // 64 single-bit beats, first bit lands in the MSB.
    for (int i = 0; i < 64; i++) begin
      c_iv = 1'b1;
      c_din = pat[63 - i];
      if (i == 63) begin
        #1;
        check("c_valid_before_last", 64'(c_out_valid), 64'h0);
      end
      @(posedge CLK);
      #1;
    end
    c_iv = 1'b0;
    check("c_frame", c_data, 64'hDEAD_BEEF_0123_4567);
    check("c_valid", 64'(c_out_valid), 64'h1);
    check("c_cnt", 64'(c_frame_cnt), 64'h1);
    c_ordy = 1'b1;
    @(posedge CLK);
    #1;
    c_ordy = 1'b0;
    check("c_delivered", 64'(c_out_valid), 64'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/serial_frame_deserializer.md
SERIAL_FRAME_DESERIALIZER -- requirements
Module: serial_frame_deserializer

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 64, meaning frame width in bits.
REQ-002 The block SHALL have parameter LANES, default 1, meaning serial bits accepted per beat; DATA_SIZE % LANES == 0 and 1 <= LANES <= DATA_SIZE.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning shift direction: 1 shifts toward MSB, 0 shifts toward LSB.
REQ-004 The block SHALL have port CLK, input, 1, clock.
REQ-005 The block SHALL have port RST, input, 1, reset, asynchronous, active-high.
REQ-006 The block SHALL have port DATA_IN, input, LANES, serial beat payload.
REQ-007 The block SHALL have port IN_VALID, input, 1, beat offered.
REQ-008 The block SHALL have port IN_READY, output, 1, beat can be accepted.
REQ-009 The block SHALL have port ALIGN, input, 1, discard partial frame.
REQ-010 The block SHALL have port DATA, output, DATA_SIZE, held completed frame.
REQ-011 The block SHALL have port OUT_VALID, output, 1, DATA holds an undelivered frame.
REQ-012 The block SHALL have port OUT_READY, input, 1, consumer takes DATA.
REQ-013 The block SHALL have port FRAME_CNT, output, 16, count of frames loaded into DATA, wrapping.

Function
REQ-014 A beat SHALL be accepted on a rising CLK edge when IN_VALID && IN_READY && !ALIGN.
REQ-015 BEATS SHALL equal DATA_SIZE/LANES; an internal beat counter SHALL run 0..BEATS-1 and wrap to 0 on the final beat.
REQ-016 With MSB_FIRST=1, an accepted beat SHALL set shift_reg to {shift_reg[DATA_SIZE-LANES-1:0], DATA_IN}, with the first beat ending in the top LANES bits.
REQ-017 With MSB_FIRST=0, an accepted beat SHALL set shift_reg to {DATA_IN, shift_reg[DATA_SIZE-1:LANES]}, with the first beat ending in the bottom LANES bits.
REQ-018 When LANES == DATA_SIZE, an accepted beat SHALL be the whole frame, with no zero-width slice.
REQ-019 On the final beat, the completed frame, including that beat, SHALL load DATA directly on the same edge; OUT_VALID SHALL be 1 in the following cycle; latency from final beat to OUT_VALID SHALL be 1 edge.
REQ-020 On the final-beat edge, shift_reg SHALL clear to 0 and FRAME_CNT SHALL increment, wrapping 16'hFFFF to 0.
REQ-021 IN_READY SHALL equal (beat_cnt != BEATS-1) || !OUT_VALID || OUT_READY, combinational; no frame SHALL be lost or overwritten.
REQ-022 OUT_VALID && OUT_READY SHALL clear OUT_VALID, unless a final beat loads a new frame on the same edge, in which case OUT_VALID SHALL stay 1 with the new DATA, giving one frame per BEATS cycles with no bubble.
REQ-023 DATA SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-024 ALIGN=1 SHALL clear beat_cnt and shift_reg on the edge, SHALL take priority over a simultaneous beat (beat dropped), and SHALL NOT affect DATA, OUT_VALID or FRAME_CNT.
REQ-025 IN_READY SHALL NOT depend on ALIGN.

Reset
REQ-026 RST=1 SHALL asynchronously force shift_reg=0, beat_cnt=0, DATA=0, OUT_VALID=0 and FRAME_CNT=0, including mid-frame and with a frame held.
REQ-027 IN_READY SHALL be 1 while and after reset, and the first accepted beat after RST deasserts SHALL be beat 0.

Structure
REQ-028 The shared package conway_hw_pkg SHALL hold DEFAULT_BOARD_WIDTH=64, FRAME_CNT_W=16, and a beat-counter width function, max(1,$clog2(BEATS)).
REQ-029 The shift_reg and beat_cnt path SHALL be one sub-module, shift_accumulator (parameters DATA_SIZE, LANES, MSB_FIRST); the output holding register and handshake SHALL stay in the top module.

Verification
REQ-030 Bench SHALL cover: DATA_SIZE=8, LANES=2, MSB_FIRST=1, beats 2'b10,2'b11,2'b00,2'b01 -> DATA=8'hB1, OUT_VALID one edge after beat 4, FRAME_CNT=1.
REQ-031 Bench SHALL cover: same beats with MSB_FIRST=0 -> DATA=8'h4E.
REQ-032 Bench SHALL cover: OUT_READY=0, two full frames offered back-to-back -> first frame held unchanged, IN_READY=0 while beat_cnt=3, raising OUT_READY delivers frame 1 then frame 2 with no loss, FRAME_CNT=2.
REQ-033 Bench SHALL cover: OUT_READY=1, continuous IN_VALID -> OUT_VALID stays 1 and DATA updates every 4 cycles.
REQ-034 Bench SHALL cover: ALIGN asserted after 2 beats, concurrent with a valid beat -> that beat dropped, next 4 beats form a fresh frame, held DATA untouched.
REQ-035 Bench SHALL cover: RST pulsed between edges mid-frame with a frame held -> all outputs 0 immediately, IN_READY=1; DATA_SIZE=64, LANES=1 -> 64 single-bit beats reproduce legacy MSB-first shift order.
